pc_fetch_unit: RTL and testbench

//  Stage-1 fetch: PC register plus I-cache request/response sequencer. Drives pc_4 into the

---
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: stage-1 fetch. Owns the PC register, sequences a single
// outstanding I-cache request at a time, and hands {pc, inst} to stage 2
// over a valid/ready interface. Stage-2 redirects squash in-flight fetches.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    output logic [31:0] pc_4,
    output logic        icache_req_valid,
    input  logic        icache_req_ready,
    output logic [31:0] icache_addr,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_inst
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] hold_inst;
    logic [31:0] pc_load;
    logic        load_pc;
    logic        latch_hold;
    logic        clear_hold;

    // The PC is always word aligned, so the low two bits of the mux result are dropped.
    assign pc_load     = pc_next & 32'hFFFF_FFFC;
    assign pc_4        = pc + 32'd4;
    assign icache_addr = pc;
    assign fetch_pc    = pc;

    // State, PC and hold register; reset may land at any point, including mid-request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            hold_inst <= NOP_INST;
        end else begin
            state <= next_state;
            if (load_pc) begin
                pc <= pc_load;
            end
            if (latch_hold) begin
                hold_inst <= icache_resp_data;
            end else if (clear_hold) begin
                hold_inst <= NOP_INST;
            end
        end
    end

    // Next-state and output decode; redirect is tested before delivery everywhere it matters.
    always_comb begin
        next_state       = state;
        load_pc          = 1'b0;
        latch_hold       = 1'b0;
        clear_hold       = 1'b0;
        icache_req_valid = 1'b0;
        fetch_valid      = 1'b0;
        fetch_inst       = hold_inst;
        case (state)
            S_BOOT: begin
                next_state = S_REQ;
            end
            S_REQ: begin
                icache_req_valid = 1'b1;
                if (redirect) begin
                    load_pc = 1'b1;
                    if (icache_req_ready) begin
                        next_state = S_DROP;
                    end
                end else if (icache_req_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                fetch_valid = icache_resp_valid;
                if (icache_resp_valid) begin
                    fetch_inst = icache_resp_data;
                end
                if (redirect) begin
                    load_pc    = 1'b1;
                    next_state = icache_resp_valid ? S_REQ : S_DROP;
                end else if (icache_resp_valid && fetch_ready) begin
                    load_pc    = 1'b1;
                    next_state = S_REQ;
                end else if (icache_resp_valid) begin
                    latch_hold = 1'b1;
                    next_state = S_OUT;
                end
            end
            S_OUT: begin
                fetch_valid = 1'b1;
                if (redirect || fetch_ready) begin
                    load_pc    = 1'b1;
                    clear_hold = 1'b1;
                    next_state = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    load_pc = 1'b1;
                end
                if (icache_resp_valid) begin
                    next_state = S_REQ;
                end
            end
            default: begin
                next_state = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios for pc_fetch_unit with a delivery
// scoreboard. Expected {pc, inst} pairs are queued when a deliverable
// response is driven and popped whenever stage 2 accepts an instruction.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_4;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;

    int          vectors;
    int          errors;
    logic [63:0] exp_q[$];

    pc_fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc_next          (pc_next),
        .redirect         (redirect),
        .pc_4             (pc_4),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_addr      (icache_addr),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_data (icache_resp_data),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (fetch_pc),
        .fetch_inst       (fetch_inst)
    );

    // Stand-in for the next-PC mux: sequential pc_4 unless stage 2 redirects.
    assign pc_next = redirect ? target : pc_4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as seen by the bench's I-cache.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Advance one clock; at the falling edge pop and compare any accepted delivery.
    task automatic cyc();
        logic [63:0] exp;
        @(negedge clk);
        if (reset_n && fetch_valid && fetch_ready && !redirect) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL delivery_unexpected: got pc=%h inst=%h, required no delivery", fetch_pc, fetch_inst);
            end else begin
                exp = exp_q.pop_front();
                if ({fetch_pc, fetch_inst} !== exp) begin
                    errors++;
                    $display("[TB] FAIL delivery: got pc=%h inst=%h, required pc=%h inst=%h", fetch_pc, fetch_inst, exp[63:32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b required 0", icache_req_valid); end
        vectors++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_valid: got %b required 0", fetch_valid); end
        vectors++; if (fetch_pc !== 32'h2000) begin errors++; $display("[TB] FAIL rst_fetch_pc: got %h required 00002000", fetch_pc); end
        vectors++; if (fetch_inst !== NOP) begin errors++; $display("[TB] FAIL rst_fetch_inst: got %h required %h", fetch_inst, NOP); end
        vectors++; if (pc_4 !== 32'h2004) begin errors++; $display("[TB] FAIL rst_pc_4: got %h required 00002004", pc_4); end
        cyc();
        reset_n = 1'b1;
        #1;
        vectors++; if (icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_req_valid: got %b required 0", icache_req_valid); end
        cyc();
        icache_req_ready = 1'b1;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h2000) begin errors++; $display("[TB] FAIL first_req: got v=%b addr=%h required v=1 addr=00002000", icache_req_valid, icache_addr); end
        cyc();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'h1111_1111;
        reset_n           = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_wait: got req=%b fv=%b required 0 0", icache_req_valid, fetch_valid); end
        vectors++; if (icache_addr !== 32'h2000 || fetch_inst !== NOP) begin errors++; $display("[TB] FAIL rst_mid_wait_pc: got addr=%h inst=%h required 00002000 %h", icache_addr, fetch_inst, NOP); end
        cyc();
        reset_n = 1'b1;
        #1;
        vectors++; if (icache_req_valid !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_after_rst: got req=%b fv=%b required 0 0", icache_req_valid, fetch_valid); end
        cyc();
        icache_resp_valid = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h2000) begin errors++; $display("[TB] FAIL req_after_rst: got v=%b addr=%h required v=1 addr=00002000", icache_req_valid, icache_addr); end
    endtask

    task automatic test_straight_line();
        logic [31:0] p;
        for (int k = 0; k < 3; k++) begin
            p = 32'h2000 + 32'(4 * k);
            icache_req_ready = 1'b1;
            #1;
            vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== p) begin errors++; $display("[TB] FAIL seq_req: got v=%b addr=%h required v=1 addr=%h", icache_req_valid, icache_addr, p); end
            vectors++; if (pc_4 !== p + 32'd4) begin errors++; $display("[TB] FAIL seq_pc_4: got %h required %h", pc_4, p + 32'd4); end
            cyc();
            icache_req_ready  = 1'b0;
            icache_resp_valid = 1'b1;
            icache_resp_data  = mem_word(p);
            exp_q.push_back({p, mem_word(p)});
            #1;
            vectors++; if (fetch_valid !== 1'b1 || icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_resp: got fv=%b req=%b required 1 0", fetch_valid, icache_req_valid); end
            cyc();
            icache_resp_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        p = 32'h200C;
        icache_req_ready = 1'b1;
        cyc();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(p);
        fetch_ready       = 1'b0;
        exp_q.push_back({p, mem_word(p)});
        cyc();
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== p || fetch_inst !== mem_word(p)) begin errors++; $display("[TB] FAIL stall_hold: got fv=%b pc=%h inst=%h required 1 %h %h", fetch_valid, fetch_pc, fetch_inst, p, mem_word(p)); end
            vectors++; if (icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_req: got %b required 0", icache_req_valid); end
            cyc();
        end
        fetch_ready = 1'b1;
        cyc();
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== p + 32'd4) begin errors++; $display("[TB] FAIL stall_next_req: got v=%b addr=%h required v=1 addr=%h", icache_req_valid, icache_addr, p + 32'd4); end
    endtask

    task automatic test_redirect_wait();
        icache_req_ready = 1'b1;
        cyc();
        icache_req_ready = 1'b0;
        redirect         = 1'b1;
        target           = 32'h3000;
        #1;
        vectors++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_wait_fv: got %b required 0", fetch_valid); end
        cyc();
        redirect          = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(32'h2010);
        #1;
        vectors++; if (fetch_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_late_resp: got fv=%b req=%b required 0 0", fetch_valid, icache_req_valid); end
        cyc();
        icache_resp_valid = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h3000) begin errors++; $display("[TB] FAIL redir_target_req: got v=%b addr=%h required v=1 addr=00003000", icache_req_valid, icache_addr); end
        icache_req_ready = 1'b1;
        redirect         = 1'b1;
        target           = 32'h3200;
        cyc();
        icache_req_ready = 1'b0;
        target           = 32'h3000;
        #1;
        vectors++; if (icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_req_valid: got %b required 0", icache_req_valid); end
        cyc();
        redirect          = 1'b0;
        icache_resp_valid = 1'b1;
        #1;
        vectors++; if (fetch_valid !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_still: got fv=%b req=%b required 0 0", fetch_valid, icache_req_valid); end
        cyc();
        icache_resp_valid = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h3000) begin errors++; $display("[TB] FAIL drop_latest_target: got v=%b addr=%h required v=1 addr=00003000", icache_req_valid, icache_addr); end
    endtask

    task automatic test_redirect_resp();
        icache_req_ready = 1'b1;
        cyc();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(32'h3000);
        redirect          = 1'b1;
        target            = 32'h4000;
        cyc();
        icache_resp_valid = 1'b0;
        redirect          = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h4000) begin errors++; $display("[TB] FAIL redir_resp_req: got v=%b addr=%h required v=1 addr=00004000", icache_req_valid, icache_addr); end
        redirect = 1'b1;
        target   = 32'h5000;
        cyc();
        redirect = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h5000) begin errors++; $display("[TB] FAIL redir_req_switch: got v=%b addr=%h required v=1 addr=00005000", icache_req_valid, icache_addr); end
        icache_req_ready = 1'b1;
        cyc();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(32'h5000);
        fetch_ready       = 1'b0;
        cyc();
        icache_resp_valid = 1'b0;
        redirect          = 1'b1;
        target            = 32'h6000;
        fetch_ready       = 1'b1;
        #1;
        vectors++; if (fetch_valid !== 1'b1 || fetch_inst !== mem_word(32'h5000)) begin errors++; $display("[TB] FAIL out_before_squash: got fv=%b inst=%h required 1 %h", fetch_valid, fetch_inst, mem_word(32'h5000)); end
        cyc();
        redirect = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h6000) begin errors++; $display("[TB] FAIL out_squash_req: got v=%b addr=%h required v=1 addr=00006000", icache_req_valid, icache_addr); end
    endtask

    task automatic test_wrap_align();
        redirect = 1'b1;
        target   = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        #1;
        vectors++; if (icache_addr !== 32'hFFFF_FFFC || pc_4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc_4: got addr=%h pc_4=%h required fffffffc 00000000", icache_addr, pc_4); end
        icache_req_ready = 1'b1;
        cyc();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = mem_word(32'hFFFF_FFFC);
        exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        cyc();
        icache_resp_valid = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h0 || pc_4 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_next_req: got v=%b addr=%h pc_4=%h required 1 00000000 00000004", icache_req_valid, icache_addr, pc_4); end
        redirect = 1'b1;
        target   = 32'h3002;
        cyc();
        redirect = 1'b0;
        #1;
        vectors++; if (icache_req_valid !== 1'b1 || icache_addr !== 32'h3000) begin errors++; $display("[TB] FAIL align_req: got v=%b addr=%h required v=1 addr=00003000", icache_req_valid, icache_addr); end
    endtask

    // Scenario sequence, ending with a scoreboard drain check and the summary.
    initial begin
        vectors           = 0;
        errors            = 0;
        reset_n           = 1'b1;
        redirect          = 1'b0;
        target            = 32'h0;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'h0;
        fetch_ready       = 1'b1;
        #2;
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap_align();
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d undelivered, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Bound on total run time in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
